// File: rtl/pipeline_stage_register_if.sv
// ---------------------------------------------------------------------------
// pipeline_stage_register_if
//
// Purpose: valid/ready handshake bundle between a producer stage, the
// pipeline_stage_register and a consumer stage.
//
// Signals:
//   in_valid   producer presents in_data
//   in_ready   stage accepts in_data this cycle
//   in_data    producer word (WORD_LENGTH bits)
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_data   head word (WORD_LENGTH bits)
//   occupancy  number of held entries (0..2)
//
// Modports:
//   master  environment side (producer + consumer)
//   slave   the pipeline stage register itself
// ---------------------------------------------------------------------------
interface pipeline_stage_register_if #(
    parameter int unsigned WORD_LENGTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_LENGTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_LENGTH-1:0] out_data;
    logic [1:0]             occupancy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );
endinterface

// File: rtl/pipeline_stage_register.sv
// ---------------------------------------------------------------------------
// pipeline_stage_register
//
// Purpose: valid/ready pipeline register placed between datapath stages.
// Holds one word (default) or two words (skid buffer), supports a
// synchronous flush for branch/exception squashing, an input-acceptance
// enable and an occupancy report. Data order is strict FIFO.
//
// Compile-time option:
//   PIPELINE_STAGE_REGISTER_SKID_EN  defined   -> two entries, registered
//                                                in_ready, occupancy 0..2
//                                    undefined -> one entry, in_ready
//                                                combinational from
//                                                out_ready, occupancy 0..1
//
// Parameters:
//   WORD_LENGTH  data word width
//   RESET_VALUE  value loaded into storage on reset and on flush
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset (highest priority)
//   enable  low blocks input acceptance; output side keeps draining
//   flush   synchronous squash of all held entries (second priority)
//   bus     handshake bundle (slave modport): in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data, occupancy
// ---------------------------------------------------------------------------
module pipeline_stage_register #(
    parameter int unsigned            WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flush,
    pipeline_stage_register_if.slave      bus
);

    logic [WORD_LENGTH-1:0] main_q;
    logic                   valid_q;
    logic                   accept;
    logic                   pop;

    assign accept = bus.in_valid & bus.in_ready;
    assign pop    = valid_q & bus.out_ready;

    assign bus.out_valid = valid_q;
    assign bus.out_data  = main_q;

`ifdef PIPELINE_STAGE_REGISTER_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state;
    logic [WORD_LENGTH-1:0] skid_q;
    logic                   ready_q;

    // ready_q tracks (next state != FULL), so in_ready never depends
    // combinationally on out_ready.
    assign bus.in_ready  = enable & ~flush & ~reset & ready_q;

    // State encoding equals the entry count, so occupancy is the register.
    assign bus.occupancy = state;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state   <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= bus.in_data;
                        valid_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_q <= bus.in_data;
                    end else if (accept) begin
                        // Consumer stalled: park the new word behind the head.
                        skid_q  <= bus.in_data;
                        ready_q <= 1'b0;
                        state   <= FULL;
                    end else if (pop) begin
                        // main_q keeps its last value while empty.
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_q  <= skid_q;
                        ready_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`else

    typedef enum logic {
        EMPTY = 1'b0,
        ONE   = 1'b1
    } state_t;

    state_t state;

    // Single entry: a new word may enter only when the slot is free or is
    // being vacated this cycle (combinational from out_ready).
    assign bus.in_ready  = enable & ~flush & ~reset & (~valid_q | bus.out_ready);
    assign bus.occupancy = {1'b0, valid_q};

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state   <= EMPTY;
            main_q  <= RESET_VALUE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= bus.in_data;
                        valid_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    // An accept here always coincides with a pop.
                    if (accept) begin
                        main_q <= bus.in_data;
                    end else if (pop) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stage_register
//
// Purpose: self-checking bench for pipeline_stage_register. A queue-based
// reference model (capacity 2 with PIPELINE_STAGE_REGISTER_SKID_EN, else 1)
// predicts every output each cycle; directed scenarios cover reset,
// streaming, back-pressure, flush and enable, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_pipeline_stage_register;

    localparam int unsigned  WL = 32;
    localparam logic [31:0]  RV = 32'hDEAD_BEEF;
`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic flush;

    pipeline_stage_register_if #(.WORD_LENGTH(WL)) bus ();

    pipeline_stage_register #(
        .WORD_LENGTH (WL),
        .RESET_VALUE (RV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;

    logic [31:0] mq[$];          // model contents, head first
    logic [31:0] shown = RV;     // model value of out_data when empty
    logic [31:0] src[$];         // producer words waiting to be offered
    logic [31:0] pops_seen[$];   // words the consumer took from the DUT
    int unsigned pop_cyc[$];
    logic        last_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs on the falling edge,
    // then advance the model across the rising edge.
    task automatic step(input logic rst, input logic en, input logic fl,
                        input logic ordy, input logic vld);
        logic        exp_v;
        logic [31:0] exp_d;
        logic [1:0]  exp_occ;
        logic        exp_rdy;
        logic        acc_dut;
        logic        acc_m;
        logic        pop_m;
        logic [31:0] popped;
        reset         = rst;
        enable        = en;
        flush         = fl;
        bus.out_ready = ordy;
        bus.in_valid  = vld && (src.size() > 0);
        bus.in_data   = (src.size() > 0) ? src[0] : $urandom;
        @(negedge clk);
        exp_v   = (mq.size() != 0);
        exp_d   = exp_v ? mq[0] : shown;
        exp_occ = 2'(mq.size());
        exp_rdy = en & ~fl & ~rst &
                  (SKID ? (mq.size() < 2) : ((mq.size() == 0) || ordy));
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
        check("out_data",  bus.out_data, exp_d);
        check("occupancy", {30'b0, bus.occupancy}, {30'b0, exp_occ});
        check("in_ready",  {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        last_rdy = bus.in_ready;
        acc_dut  = bus.in_valid & bus.in_ready;
        if (bus.out_valid && ordy) begin
            pops_seen.push_back(bus.out_data);
            pop_cyc.push_back(cyc);
        end
        acc_m = bus.in_valid & exp_rdy;
        pop_m = exp_v & ordy;
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
            shown = RV;
        end else begin
            if (pop_m) begin
                popped = mq.pop_front();
                shown  = popped;
            end
            if (acc_m) mq.push_back(bus.in_data);
            if (mq.size() > 0) shown = mq[0];
        end
        if (acc_dut) void'(src.pop_front());
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        reset         = 1'b1;
        enable        = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles, then first cycle after release.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_reset_in_ready", {31'b0, last_rdy}, 32'd1);

        // Streaming 1..8 with out_ready high.
        pops_seen.delete();
        pop_cyc.delete();
        for (int i = 1; i <= 8; i++) src.push_back(32'(i));
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("stream_count", pops_seen.size(), 32'd8);
        for (int i = 0; i < 8 && i < pops_seen.size(); i++) begin
            check("stream_word", pops_seen[i], 32'(i + 1));
            check("stream_gap", pop_cyc[i] - pop_cyc[0], 32'(i));
        end

`ifdef PIPELINE_STAGE_REGISTER_SKID_EN
        // Back-pressure: A and B fill the stage, C waits at the producer.
        pops_seen.delete();
        src.delete();
        src.push_back(32'h0000_00A1);
        src.push_back(32'h0000_00B2);
        src.push_back(32'h0000_00C3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("bp_in_ready_after_b", {31'b0, last_rdy}, 32'd0);
        check("bp_occupancy", {30'b0, bus.occupancy}, 32'd2);
        check("bp_c_held", src.size(), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("bp_pop_count", pops_seen.size(), 32'd3);
        if (pops_seen.size() == 3) begin
            check("bp_pop_a", pops_seen[0], 32'h0000_00A1);
            check("bp_pop_b", pops_seen[1], 32'h0000_00B2);
            check("bp_pop_c", pops_seen[2], 32'h0000_00C3);
        end
`endif

        // Flush while holding data, with a pop and an offered word together.
        src.delete();
        src.push_back(32'h1111_0001);
        src.push_back(32'h1111_0002);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        src.push_back(32'h1111_0003);
        n = src.size();
        pops_seen.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("flush_no_accept", src.size(), n);
        check("flush_pop_count", pops_seen.size(), 32'd1);
        if (pops_seen.size() > 0) check("flush_pop_word", pops_seen[0], 32'h1111_0001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("flush_out_data", bus.out_data, RV);
        src.delete();

        // Enable low blocks acceptance while the held word drains.
        src.push_back(32'h2222_0001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        src.push_back(32'h2222_0002);
        pops_seen.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            check("en_in_ready", {31'b0, last_rdy}, 32'd0);
        end
        check("en_no_accept", src.size(), 32'd1);
        check("en_pop_count", pops_seen.size(), 32'd1);
        if (pops_seen.size() > 0) check("en_pop_word", pops_seen[0], 32'h2222_0001);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("en_accept_resumes", src.size(), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if (src.size() < 4) src.push_back($urandom);
            step($urandom_range(99) < 2,
                 $urandom_range(99) < 85,
                 $urandom_range(99) < 5,
                 1'($urandom_range(1)),
                 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
